// File: rtl/button_conditioner.sv
// button_conditioner
// Per-channel synchroniser, stability-counter debouncer and rising-edge
// strobe generator. Channels are independent; every output is a flop, so
// there is no path from the raw inputs to the outputs through logic alone.
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] button_raw,
  output logic [N_BTN-1:0] button_level,
  output logic [N_BTN-1:0] button_pulse,
  output logic             any_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value on which a continuing mismatch is accepted as the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt  [N_BTN];
  logic [N_BTN-1:0] r_level;
  logic [N_BTN-1:0] r_pulse;
  logic             r_any;

  logic [N_BTN-1:0] w_sync;
  logic [CNT_W-1:0] w_cnt_nxt [N_BTN];
  logic [N_BTN-1:0] w_level_nxt;
  logic [N_BTN-1:0] w_pulse_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchroniser chain: raw inputs enter stage 0, stage SYNC_STAGES-1 feeds the debouncer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= button_raw;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // Debounce decision: count consecutive mismatches, commit on the last one.
  // A commit to 1 also raises the strobe; a commit to 0 only moves the level.
  always_comb begin
    w_level_nxt = r_level;
    w_pulse_nxt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_sync[i] != r_level[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_level_nxt[i] = w_sync[i];
          w_pulse_nxt[i] = w_sync[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state and registered outputs; any_pulse is built from next-state
  // strobes so it lines up with button_pulse rather than trailing it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_BTN; i++) r_cnt[i] <= '0;
      r_level <= '0;
      r_pulse <= '0;
      r_any   <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
      r_any   <= |w_pulse_nxt;
    end
  end

  assign button_level = r_level;
  assign button_pulse = r_pulse;
  assign any_pulse    = r_any;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (N_BTN=5, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Stimulus pushes each expected strobe (cycle, vector)
// into a queue; a monitor pops one entry whenever a strobe appears.
module tb_button_conditioner;

  localparam int NB = 5;
  localparam int LAT = 6;  // SYNC_STAGES + DEBOUNCE_CYCLES

  typedef struct {
    int            cyc;
    logic [NB-1:0] vec;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [NB-1:0] button_raw;
  logic [NB-1:0] button_level;
  logic [NB-1:0] button_pulse;
  logic          any_pulse;

  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t exp_q [$];

  button_conditioner #(
    .N_BTN(NB),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_raw(button_raw),
    .button_level(button_level),
    .button_pulse(button_pulse),
    .any_pulse(any_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe expected LAT edges after the edge following the current drive point.
  task automatic expect_pulse(input logic [NB-1:0] vec);
    exp_t e;
    e.cyc = cyc + LAT;
    e.vec = vec;
    exp_q.push_back(e);
  endtask

  // Monitor: any strobe on either output must match the head of the queue.
  always @(negedge clk) begin
    if (reset && (button_pulse != '0 || any_pulse)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: got pulse=%b any=%b at cycle %0d, none expected",
                 button_pulse, any_pulse, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_vec", 32'(button_pulse), 32'(e.vec));
        check("any_pulse", 32'(any_pulse), 32'd1);
      end
    end
  end

  initial begin
    cyc        = 0;
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b0;
    button_raw = '0;
    tick(3);
    check("reset_level", 32'(button_level), 32'd0);
    check("reset_pulse", 32'(button_pulse), 32'd0);
    check("reset_any", 32'(any_pulse), 32'd0);
    reset = 1'b1;
    tick(3);

    // 1: clean press on ch0, held 20 cycles, then release
    button_raw = 5'b00001;
    expect_pulse(5'b00001);
    tick(LAT - 1);
    check("clean_level_before", 32'(button_level), 32'd0);
    tick(1);
    check("clean_level_commit", 32'(button_level), 32'b00001);
    tick(14);
    check("clean_level_held", 32'(button_level), 32'b00001);
    button_raw = '0;
    tick(LAT - 1);
    check("release_level_before", 32'(button_level), 32'b00001);
    tick(1);
    check("release_level_fall", 32'(button_level), 32'd0);
    tick(4);

    // 2: bouncing press on ch2: 1,0,1,0,1 then held
    button_raw = 5'b00100; tick(1);
    button_raw = 5'b00000; tick(1);
    button_raw = 5'b00100; tick(1);
    button_raw = 5'b00000; tick(1);
    button_raw = 5'b00100;
    expect_pulse(5'b00100);
    tick(LAT - 1);
    check("bounce_level_before", 32'(button_level), 32'd0);
    tick(1);
    check("bounce_level_commit", 32'(button_level), 32'b00100);
    tick(4);
    button_raw = '0;
    tick(10);
    check("bounce_level_released", 32'(button_level), 32'd0);

    // 3: three-cycle glitch on ch3 is rejected
    button_raw = 5'b01000;
    tick(3);
    button_raw = '0;
    tick(10);
    check("glitch_level", 32'(button_level), 32'd0);

    // 4: simultaneous presses
    button_raw = 5'b10101;
    expect_pulse(5'b10101);
    tick(LAT);
    check("simul_level", 32'(button_level), 32'b10101);
    tick(4);
    button_raw = '0;
    tick(10);
    check("simul_level_released", 32'(button_level), 32'd0);

    // 5: reset mid-count on ch1 while ch0 is already committed high
    button_raw = 5'b00001;
    expect_pulse(5'b00001);
    tick(10);
    check("pre_reset_level", 32'(button_level), 32'b00001);
    button_raw = 5'b00011;
    tick(3);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_level_immediate", 32'(button_level), 32'd0);
    check("rst_pulse_immediate", 32'(button_pulse), 32'd0);
    check("rst_any_immediate", 32'(any_pulse), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    expect_pulse(5'b00011);
    @(negedge clk);
    tick(LAT - 1);
    check("post_rst_level_before", 32'(button_level), 32'd0);
    tick(1);
    check("post_rst_level_commit", 32'(button_level), 32'b00011);
    button_raw = '0;
    tick(12);

    // 6: long hold on ch4, release, re-press: exactly two strobes
    button_raw = 5'b10000;
    expect_pulse(5'b10000);
    tick(100);
    check("long_level_held", 32'(button_level), 32'b10000);
    button_raw = '0;
    tick(10);
    check("long_level_released", 32'(button_level), 32'd0);
    button_raw = 5'b10000;
    expect_pulse(5'b10000);
    tick(10);
    check("repress_level", 32'(button_level), 32'b10000);
    button_raw = '0;
    tick(12);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Per-button input conditioner that sits directly upstream of the lamp-toggle stage. It synchronises each raw push-button input to `clk`, debounces it with a per-channel stability counter, and emits a one-cycle pulse on each debounced press, so the toggle stage flips its lamp exactly once per physical press. All channels are independent and identical.

## Interface

- `N_BTN`, default 5: number of button channels.
- `SYNC_STAGES`, default 2: synchroniser flop depth. Legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required to accept a new level. Legal range ≥ 1.

Ports, clock and reset first:

- `clk`  input  1  the block's single clock. All state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset. `reset` = 0 clears all state immediately, independent of `clk`.
- `button_raw`  input  N_BTN  raw, asynchronous, bouncing button levels. 1 = pressed.
- `button_level`  output  N_BTN  debounced, registered button level.
- `button_pulse`  output  N_BTN  one-cycle strobe per debounced rising edge. Drives the toggle stage's `button` input.
- `any_pulse`  output  1  registered OR of the `button_pulse` bits, asserted in the same cycle as them.

## Operation

Each channel `i` contains the following state:

- **Synchroniser:** a chain of `SYNC_STAGES` flops on `button_raw[i]`. Its final stage is `sync[i]`.
- **Counter:** `cnt[i]`, width clog2(DEBOUNCE_CYCLES+1).
- **Level register:** `level[i]`, which drives `button_level[i]`.

Per-edge rules, evaluated using pre-edge values:

- If `sync[i]` == `level[i]`: `cnt[i]` <= 0. Any mismatch shorter than the threshold is discarded.
- If `sync[i]` != `level[i]` and `cnt[i]` < DEBOUNCE_CYCLES-1: `cnt[i]` <= `cnt[i]`+1.
- If `sync[i]` != `level[i]` and `cnt[i]` == DEBOUNCE_CYCLES-1: this is the **commit** case.
  - `level[i]` <= `sync[i]` and `cnt[i]` <= 0.
  - `button_pulse[i]` <= `sync[i]`, so the pulse fires only on a 0→1 commit.
- In all non-commit cases, `button_pulse[i]` <= 0.
- `any_pulse` <= the OR, over all channels, of each channel's next-state `button_pulse` value.

Behavioural consequences:

- With DEBOUNCE_CYCLES = 1, commit happens on the first mismatching sample.
- A release (1→0 commit) updates `level` and never pulses.
- A held button produces exactly one pulse, whatever the hold length.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

Reset state (`reset` = 0):

- All synchroniser flops, `cnt`, `level`, `button_pulse` and `any_pulse` go to 0.
- A count in progress is discarded.
- No pulse is generated on reset assertion or on release.
- After release, a button held through reset is treated as a new press: it pulses once after the full latency.

## Timing

- **Latency.** Take raw held stable from the first edge that samples the new value, called edge 1. `sync` reflects it after edge SYNC_STAGES. The commit edge is SYNC_STAGES + DEBOUNCE_CYCLES. With the defaults that is edge 18; with S=2, D=4 it is edge 6.
- **Pulse alignment.** `button_pulse[i]`, `any_pulse` and the rising `button_level[i]` all change on the same edge. The pulse is high for exactly one cycle.
- **Filtering.** Any raw excursion that appears at `sync` for fewer than DEBOUNCE_CYCLES consecutive samples is fully rejected.
- **Back-to-back presses.** The minimum press-to-press period is 2×DEBOUNCE_CYCLES cycles: one debounced release plus one debounced press. Two pulses on the same channel are therefore never adjacent.
- **No combinational paths.** All outputs are registered; there is no input-to-output combinational path.

## Test plan

All scenarios use `N_BTN`=5, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4.

1. **Clean press.** `button_raw`=5'b00001 from edge 1, held 20 cycles → `button_pulse`=5'b00001 and `any_pulse`=1 on edge 6 only; `button_level[0]`=1 from edge 6 onward.
2. **Bouncing press.** Raw[2] toggles 1,0,1,0,1 on consecutive cycles, then stays 1 → no pulse during bounce; exactly one pulse 6 edges after the final 0→1.
3. **Short glitch and release.**
   - Raw[3] high for 3 cycles, then low → no pulse, `button_level` stays 0.
   - Release after a committed press → `button_level` falls 6 edges after the raw fall, with no pulse.
4. **Simultaneous presses.** Raw=5'b10101 applied on one edge → `button_pulse`=5'b10101 on a single cycle (edge 6), with `any_pulse`=1.
5. **Reset mid-count.**
   - Raw[1]=1, then pull `reset` low at edge 4 for 2 cycles → all outputs 0 immediately and no pulse.
   - Release `reset` with raw still 1 → pulse 6 edges after release.
6. **Long hold and re-press.** Raw[4]=1 for 100 cycles, then 0 for 10 cycles, then 1 again → exactly two pulses total on `button_pulse[4]`.
